// File: rtl/match_win_tracker_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | match_win_tracker_pkg : shared types, constants and 7-seg glyph function   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package match_win_tracker_pkg;

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    ROUND_WON = 2'd1,
    MATCH_WON = 2'd2
  } match_state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low segments ordered {g,f,e,d,c,b,a}; non-decimal codes blank.
  function automatic logic [6:0] seg7_digit(input logic [3:0] digit);
    logic [6:0] segs;
    case (digit)
      4'd0:    segs = 7'b1000000;
      4'd1:    segs = 7'b1111001;
      4'd2:    segs = 7'b0100100;
      4'd3:    segs = 7'b0110000;
      4'd4:    segs = 7'b0011001;
      4'd5:    segs = 7'b0010010;
      4'd6:    segs = 7'b0000010;
      4'd7:    segs = 7'b1111000;
      4'd8:    segs = 7'b0000000;
      4'd9:    segs = 7'b0010000;
      default: segs = SEG_BLANK;
    endcase
    return segs;
  endfunction

endpackage
`default_nettype wire

// File: rtl/match_win_tracker_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | match_win_tracker_if : playfield-side inputs and display-side outputs      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface match_win_tracker_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W     = 4
);

  logic [NUM_PLAYERS-1:0]         edge_led;
  logic [NUM_PLAYERS-1:0]         press;
  logic                           next_round;
  logic                           round_over;
  logic                           match_over;
  logic [2:0]                     winner;
  logic [NUM_PLAYERS*SCORE_W-1:0] scores;
  logic [6:0]                     hex;

  modport master (
    output edge_led, press, next_round,
    input  round_over, match_over, winner, scores, hex
  );

  modport slave (
    input  edge_led, press, next_round,
    output round_over, match_over, winner, scores, hex
  );

endinterface
`default_nettype wire

// File: rtl/match_win_tracker_seg7_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg7_decoder : decimal digit to active-low 7-segment pattern {g..a}        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module seg7_decoder
  import match_win_tracker_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] segs
);

  assign segs = seg7_digit(digit);

endmodule
`default_nettype wire

// File: rtl/match_win_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | match_win_tracker : N-player round/match referee with winner HEX digit     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module match_win_tracker
  import match_win_tracker_pkg::*;
#(
  parameter int NUM_PLAYERS   = 2,
  parameter int WINS_TO_MATCH = 3,
  parameter int SCORE_W       = 4
) (
  input  logic                Clock,
  input  logic                Reset,
  match_win_tracker_if.slave  bus
);

  match_state_t           r_state;
  match_state_t           w_next_state;
  logic [NUM_PLAYERS-1:0] r_press_q;
  logic [SCORE_W-1:0]     r_scores [NUM_PLAYERS];
  logic [2:0]             r_winner;

  logic [NUM_PLAYERS-1:0] w_rise;
  logic [NUM_PLAYERS-1:0] w_hit;
  logic                   w_hit_any;
  logic [2:0]             w_hit_idx;
  logic [SCORE_W-1:0]     w_sel_score;
  logic [SCORE_W-1:0]     w_score_inc;
  logic                   w_score_we;
  logic [3:0]             w_digit;
  logic [6:0]             w_seg;

  // Lowest-index hit wins; the loop runs high-to-low so the last match is the lowest.
  always_comb begin
    w_rise      = bus.press & ~r_press_q;
    w_hit       = w_rise & bus.edge_led;
    w_hit_any   = |w_hit;
    w_hit_idx   = '0;
    w_sel_score = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_hit_idx   = 3'(i);
        w_sel_score = r_scores[i];
      end
    end
    w_score_inc = w_sel_score + SCORE_W'(1);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= PLAY;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_score_we   = 1'b0;
    case (r_state)
      PLAY: begin
        if (w_hit_any) begin
          w_score_we   = 1'b1;
          w_next_state = (w_score_inc == SCORE_W'(WINS_TO_MATCH)) ? MATCH_WON : ROUND_WON;
        end
      end
      ROUND_WON: begin
        if (bus.next_round) begin
          w_next_state = PLAY;
        end
      end
      MATCH_WON: w_next_state = MATCH_WON;
      default:   w_next_state = PLAY;
    endcase
  end

  // Edge history tracks every cycle regardless of state so a held button never re-scores.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_press_q <= '0;
      r_winner  <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        r_scores[i] <= '0;
      end
    end else begin
      r_press_q <= bus.press;
      if (w_score_we) begin
        r_winner <= w_hit_idx;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
          if (w_hit_idx == 3'(i)) begin
            r_scores[i] <= w_score_inc;
          end
        end
      end
    end
  end

  assign w_digit = {1'b0, r_winner} + 4'd1;

  seg7_decoder u_hex_dec (
    .digit (w_digit),
    .segs  (w_seg)
  );

  always_comb begin
    bus.round_over = (r_state != PLAY);
    bus.match_over = (r_state == MATCH_WON);
    bus.winner     = r_winner;
    bus.hex        = (r_state == PLAY) ? SEG_BLANK : w_seg;
    bus.scores     = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      bus.scores[i*SCORE_W +: SCORE_W] = r_scores[i];
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_score_chk
      a_score_max : assert property (@(posedge Clock) disable iff (Reset)
        r_scores[gi] <= SCORE_W'(WINS_TO_MATCH));
    end
  endgenerate

endmodule
`default_nettype wire
